ysyx_220053_register_file: RTL and testbench

YSYX_220053_REGISTER_FILE -- requirements
Module: ysyx_220053_register_file

---
 rtl/ysyx_220053_register_file_pkg.sv | 13 +
 rtl/ysyx_220053_rf_readport.sv | 21 ++
 rtl/ysyx_220053_register_file.sv | 70 +++++++
 tb/tb_ysyx_220053_register_file.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/ysyx_220053_register_file_pkg.sv
// Shared constants for the ysyx_220053 integer register file: default geometry
// and the index of the hardwired zero register.
package ysyx_220053_register_file_pkg;

    localparam int RF_ADDR_WIDTH = 5;
    localparam int RF_DATA_WIDTH = 64;
    localparam int ZERO_REG_IDX  = 0;

    function automatic logic is_zero_idx(input int unsigned idx);
        return idx == ZERO_REG_IDX;
    endfunction

endpackage

// File: rtl/ysyx_220053_rf_readport.sv
// One asynchronous read port of the register file; index 0 always reads as zero
// regardless of what the backing flop holds.
module ysyx_220053_rf_readport
    import ysyx_220053_register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] regs_i [2**ADDR_WIDTH],
    input  logic [ADDR_WIDTH-1:0] addr_i,
    output logic [DATA_WIDTH-1:0] data_o
);

    always_comb begin
        data_o = regs_i[addr_i];
        if (is_zero_idx(32'(addr_i))) begin
            data_o = '0;
        end
    end

endmodule

// File: rtl/ysyx_220053_register_file.sv
// 2**ADDR_WIDTH x DATA_WIDTH register file: two operand read ports plus a debug
// read port, one write port, x0 hardwired to zero, no write-to-read bypass.
module ysyx_220053_register_file
    import ysyx_220053_register_file_pkg::*;
#(
    parameter int ADDR_WIDTH = RF_ADDR_WIDTH,
    parameter int DATA_WIDTH = RF_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] raaddr,
    input  logic [ADDR_WIDTH-1:0] rbaddr,
    output logic [DATA_WIDTH-1:0] radata,
    output logic [DATA_WIDTH-1:0] rbdata,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  wen,
    input  logic [ADDR_WIDTH-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] rf_q [DEPTH];
    logic [DATA_WIDTH-1:0] rf_d [DEPTH];

    // Writes to x0 are dropped here so its flop stays at its reset value.
    always_comb begin
        rf_d = rf_q;
        if (wen && !is_zero_idx(32'(waddr))) begin
            rf_d[waddr] = wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rf_q <= '{default: '0};
        end else begin
            rf_q <= rf_d;
        end
    end

    ysyx_220053_rf_readport #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_a (
        .regs_i(rf_q),
        .addr_i(raaddr),
        .data_o(radata)
    );

    ysyx_220053_rf_readport #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_b (
        .regs_i(rf_q),
        .addr_i(rbaddr),
        .data_o(rbdata)
    );

    ysyx_220053_rf_readport #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .DATA_WIDTH(DATA_WIDTH)
    ) u_port_dbg (
        .regs_i(rf_q),
        .addr_i(dbg_addr),
        .data_o(dbg_data)
    );

endmodule

// File: tb/tb_ysyx_220053_register_file.sv
// Directed self-checking bench for ysyx_220053_register_file.
module tb_ysyx_220053_register_file;

    logic        clk;
    logic        rst;
    logic [4:0]  raaddr;
    logic [4:0]  rbaddr;
    logic [63:0] radata;
    logic [63:0] rbdata;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic        wen;
    logic [4:0]  dbg_addr;
    logic [63:0] dbg_data;

    int passed = 0;
    int total  = 0;

    ysyx_220053_register_file dut (
        .clk     (clk),
        .rst     (rst),
        .raaddr  (raaddr),
        .rbaddr  (rbaddr),
        .radata  (radata),
        .rbdata  (rbdata),
        .waddr   (waddr),
        .wdata   (wdata),
        .wen     (wen),
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i);
        return {32'(i) + 32'h0000_0100, 32'hC0DE_0000 + 32'(i)};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [4:0] a, input logic [63:0] d);
        wen   = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        wen   = 1'b0;
    endtask

    initial begin
        logic [63:0] exp;
        rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
        raaddr = '0; rbaddr = '0; dbg_addr = '0;
        tick();
        rst = 1'b0;

        // Fill every entry, then reset with a competing write: all must read zero.
        for (int i = 0; i < 32; i++) write(5'(i), pat(i));
        rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 64'hAB;
        tick();
        rst = 1'b0; wen = 1'b0;
        for (int i = 0; i < 32; i++) begin
            raaddr = 5'(i); rbaddr = 5'(31 - i); dbg_addr = 5'((i + 11) % 32);
            #1;
            check($sformatf("reset_a[%0d]", i), radata, 64'h0);
            check($sformatf("reset_b[%0d]", 31 - i), rbdata, 64'h0);
            check($sformatf("reset_dbg[%0d]", (i + 11) % 32), dbg_data, 64'h0);
        end

        // Basic write/read with all three ports on the same index.
        write(5'd5, 64'h0000_0000_DEAD_BEEF);
        raaddr = 5'd5; rbaddr = 5'd5; dbg_addr = 5'd5; #1;
        check("wr5_a", radata, 64'h0000_0000_DEAD_BEEF);
        check("wr5_b", rbdata, 64'h0000_0000_DEAD_BEEF);
        check("wr5_dbg", dbg_data, 64'h0000_0000_DEAD_BEEF);

        // x0 is hardwired.
        write(5'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        raaddr = 5'd0; rbaddr = 5'd0; dbg_addr = 5'd0; #1;
        check("x0_a", radata, 64'h0);
        check("x0_b", rbdata, 64'h0);
        check("x0_dbg", dbg_data, 64'h0);

        // No bypass: old value before the edge, new value right after.
        write(5'd3, 64'h11);
        wen = 1'b1; waddr = 5'd3; wdata = 64'h22; raaddr = 5'd3; rbaddr = 5'd3;
        #1;
        check("nobypass_before_a", radata, 64'h11);
        check("nobypass_before_b", rbdata, 64'h11);
        tick();
        wen = 1'b0;
        check("nobypass_after_a", radata, 64'h22);

        // wen gating.
        write(5'd7, 64'h1234);
        wen = 1'b0; waddr = 5'd7; wdata = 64'h9999;
        tick();
        raaddr = 5'd7; #1;
        check("wen_gate", radata, 64'h1234);

        // Reset priority over a concurrent write.
        rst = 1'b1; wen = 1'b1; waddr = 5'd9; wdata = 64'hAB;
        tick();
        rst = 1'b0; wen = 1'b0;
        raaddr = 5'd9; rbaddr = 5'd5; dbg_addr = 5'd7; #1;
        check("rstprio_r9", radata, 64'h0);
        check("rstprio_r5", rbdata, 64'h0);
        check("rstprio_r7", dbg_data, 64'h0);

        // ADDI-style operand read.
        write(5'd1, 64'h10);
        raaddr = 5'd1; #1;
        check("addi_sum", radata + 64'd5, 64'h15);

        // Distinct pattern in every entry, read back through skewed addresses.
        for (int i = 0; i < 32; i++) write(5'(i), pat(i));
        for (int i = 0; i < 32; i++) begin
            raaddr = 5'(i); rbaddr = 5'((i + 7) % 32); dbg_addr = 5'((i + 13) % 32);
            #1;
            exp = (i == 0) ? 64'h0 : pat(i);
            check($sformatf("fill_a[%0d]", i), radata, exp);
            exp = (((i + 7) % 32) == 0) ? 64'h0 : pat((i + 7) % 32);
            check($sformatf("fill_b[%0d]", (i + 7) % 32), rbdata, exp);
            exp = (((i + 13) % 32) == 0) ? 64'h0 : pat((i + 13) % 32);
            check($sformatf("fill_dbg[%0d]", (i + 13) % 32), dbg_data, exp);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
